// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared types and helpers for the sonar ping scheduler
// Contents:
//   state_t       measurement-cycle FSM states
//   MID_DEFAULT   offset-binary zero level of the filtered sample stream
//   after_tx      state that follows TX, skipping zero-length phases
//   first_state   first active state of a new ping, skipping zero-length phases
//   magnitude     |data - mid|, saturated at mid
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TX     = 3'd1,
        ST_BLANK  = 3'd2,
        ST_LISTEN = 3'd3,
        ST_REPORT = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    localparam int MID_DEFAULT = 128;

    function automatic state_t after_tx(input logic blank_nz, input logic listen_nz);
        if (blank_nz) begin
            return ST_BLANK;
        end
        if (listen_nz) begin
            return ST_LISTEN;
        end
        return ST_REPORT;
    endfunction

    function automatic state_t first_state(input logic tx_nz, input logic blank_nz,
                                           input logic listen_nz);
        if (tx_nz) begin
            return ST_TX;
        end
        return after_tx(blank_nz, listen_nz);
    endfunction

    // Samples wider than 16 bits are not supported by this helper.
    function automatic logic [15:0] magnitude(input logic [15:0] data, input logic [15:0] mid);
        logic [15:0] diff;
        diff = (data >= mid) ? (data - mid) : (mid - data);
        return (diff > mid) ? mid : diff;
    endfunction

endpackage

// File: rtl/sonar_echo_detector.sv
// rtl/sonar_echo_detector.sv - first-crossing and peak-magnitude tracker for one listen window
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear          zero all results (asserted when a new ping is launched)
//   en             a window sample is present on data this cycle
//   data           offset-binary filtered sample
//   idx            0-based window index of the current sample
//   threshold      hit when magnitude >= threshold
//   hit            threshold crossed at least once since clear
//   first_idx      index of the first crossing (0 when no hit)
//   peak           maximum magnitude seen since clear
module sonar_echo_detector
    import sonar_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int TIME_W   = 16,
    parameter int MID      = MID_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] data,
    input  logic [TIME_W-1:0]   idx,
    input  logic [SAMPLE_W-1:0] threshold,
    output logic                hit,
    output logic [TIME_W-1:0]   first_idx,
    output logic [SAMPLE_W-1:0] peak
);

    logic                hit_q, hit_d;
    logic [TIME_W-1:0]   first_idx_q, first_idx_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic [SAMPLE_W-1:0] mag;

    always_comb begin
        mag         = SAMPLE_W'(magnitude(16'(data), 16'(MID)));
        hit_d       = hit_q;
        first_idx_d = first_idx_q;
        peak_d      = peak_q;
        if (clear) begin
            hit_d       = 1'b0;
            first_idx_d = '0;
            peak_d      = '0;
        end else if (en) begin
            // Only the first crossing is recorded; later ones leave the index alone.
            if (!hit_q && (mag >= threshold)) begin
                hit_d       = 1'b1;
                first_idx_d = idx;
            end
            if (mag > peak_q) begin
                peak_d = mag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q       <= 1'b0;
            first_idx_q <= '0;
            peak_q      <= '0;
        end else begin
            hit_q       <= hit_d;
            first_idx_q <= first_idx_d;
            peak_q      <= peak_d;
        end
    end

    assign hit       = hit_q;
    assign first_idx = first_idx_q;
    assign peak      = peak_q;

endmodule

// File: rtl/sonar_ping_scheduler.sv
// rtl/sonar_ping_scheduler.sv - sequences tone burst, ringdown blanking, listen window and result report
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   start, continuous                one-shot trigger (IDLE only), auto-repeat enable
//   tx_len, blank_len, listen_len,   phase lengths (listen_len in accepted samples,
//   gap_len, threshold               others in clk cycles), echo threshold
//   smp_valid, smp_data              filtered sample stream
//   tx_en, rx_en, busy               registered phase enables and activity flag
//   echo_valid, echo_ready           result handshake
//   echo_hit, echo_time, echo_peak   result payload
module sonar_ping_scheduler
    import sonar_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int TIME_W   = 16,
    parameter int MID      = MID_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                continuous,
    input  logic [TIME_W-1:0]   tx_len,
    input  logic [TIME_W-1:0]   blank_len,
    input  logic [TIME_W-1:0]   listen_len,
    input  logic [TIME_W-1:0]   gap_len,
    input  logic [SAMPLE_W-1:0] threshold,
    input  logic                smp_valid,
    input  logic [SAMPLE_W-1:0] smp_data,
    output logic                tx_en,
    output logic                rx_en,
    output logic                busy,
    output logic                echo_valid,
    input  logic                echo_ready,
    output logic                echo_hit,
    output logic [TIME_W-1:0]   echo_time,
    output logic [SAMPLE_W-1:0] echo_peak
);

    localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   cnt_q, cnt_d;
    logic [TIME_W-1:0]   idx_q, idx_d;
    logic [TIME_W-1:0]   tx_len_q, tx_len_d;
    logic [TIME_W-1:0]   blank_len_q, blank_len_d;
    logic [TIME_W-1:0]   listen_len_q, listen_len_d;
    logic [TIME_W-1:0]   gap_len_q, gap_len_d;
    logic [SAMPLE_W-1:0] thr_q, thr_d;
    logic                tx_en_q, tx_en_d;
    logic                rx_en_q, rx_en_d;
    logic                busy_q, busy_d;
    logic                echo_valid_q, echo_valid_d;
    logic                launch;
    logic                det_en;
    logic                xfer;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        tx_len_d     = tx_len_q;
        blank_len_d  = blank_len_q;
        listen_len_d = listen_len_q;
        gap_len_d    = gap_len_q;
        thr_d        = thr_q;
        launch       = 1'b0;
        det_en       = 1'b0;
        xfer         = echo_valid_q && echo_ready;

        // cnt_q holds the remaining cycles (or samples in LISTEN) of the
        // current phase including the present one, so a phase ends when it
        // reads 1. Zero-length phases are never entered, so it never wraps.
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    launch = 1'b1;
                end
            end
            ST_TX: begin
                if (cnt_q == ONE) begin
                    state_d = after_tx(blank_len_q != '0, listen_len_q != '0);
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_BLANK: begin
                if (cnt_q == ONE) begin
                    state_d = (listen_len_q != '0) ? ST_LISTEN : ST_REPORT;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            ST_LISTEN: begin
                if (smp_valid) begin
                    det_en = 1'b1;
                    idx_d  = idx_q + ONE;
                    if (cnt_q == ONE) begin
                        state_d = ST_REPORT;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            ST_REPORT: begin
                if (xfer) begin
                    if (!continuous) begin
                        state_d = ST_IDLE;
                    end else if (gap_len_q == '0) begin
                        launch = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == ONE) begin
                    if (continuous) begin
                        launch = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A launch snapshots the configuration; everything after it in this
        // ping uses only the latched copies.
        if (launch) begin
            tx_len_d     = tx_len;
            blank_len_d  = blank_len;
            listen_len_d = listen_len;
            gap_len_d    = gap_len;
            thr_d        = threshold;
            idx_d        = '0;
            state_d      = first_state(tx_len != '0, blank_len != '0, listen_len != '0);
        end

        if (launch || (state_d != state_q)) begin
            case (state_d)
                ST_TX:     cnt_d = tx_len_d;
                ST_BLANK:  cnt_d = blank_len_d;
                ST_LISTEN: cnt_d = listen_len_d;
                ST_GAP:    cnt_d = gap_len_d;
                default:   cnt_d = '0;
            endcase
        end

        tx_en_d      = (state_d == ST_TX);
        rx_en_d      = (state_d == ST_BLANK) || (state_d == ST_LISTEN);
        busy_d       = (state_d != ST_IDLE);
        echo_valid_d = (state_d == ST_REPORT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            tx_len_q     <= '0;
            blank_len_q  <= '0;
            listen_len_q <= '0;
            gap_len_q    <= '0;
            thr_q        <= '0;
            tx_en_q      <= 1'b0;
            rx_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            echo_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            tx_len_q     <= tx_len_d;
            blank_len_q  <= blank_len_d;
            listen_len_q <= listen_len_d;
            gap_len_q    <= gap_len_d;
            thr_q        <= thr_d;
            tx_en_q      <= tx_en_d;
            rx_en_q      <= rx_en_d;
            busy_q       <= busy_d;
            echo_valid_q <= echo_valid_d;
        end
    end

    sonar_echo_detector #(
        .SAMPLE_W (SAMPLE_W),
        .TIME_W   (TIME_W),
        .MID      (MID)
    ) u_detector (
        .clk       (clk),
        .rst       (reset),
        .clear     (launch),
        .en        (det_en),
        .data      (smp_data),
        .idx       (idx_q),
        .threshold (thr_q),
        .hit       (echo_hit),
        .first_idx (echo_time),
        .peak      (echo_peak)
    );

    assign tx_en      = tx_en_q;
    assign rx_en      = rx_en_q;
    assign busy       = busy_q;
    assign echo_valid = echo_valid_q;

endmodule

// File: tb/tb_sonar_ping_scheduler.sv
// tb/tb_sonar_ping_scheduler.sv - directed self-checking bench for sonar_ping_scheduler
module tb_sonar_ping_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        continuous;
    logic [15:0] tx_len, blank_len, listen_len, gap_len;
    logic [7:0]  threshold;
    logic        smp_valid;
    logic [7:0]  smp_data;
    logic        echo_ready;
    logic        tx_en, rx_en, busy, echo_valid, echo_hit;
    logic [15:0] echo_time;
    logic [7:0]  echo_peak;

    int n_cmp = 0;
    int n_bad = 0;

    sonar_ping_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .tx_len     (tx_len),
        .blank_len  (blank_len),
        .listen_len (listen_len),
        .gap_len    (gap_len),
        .threshold  (threshold),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .tx_en      (tx_en),
        .rx_en      (rx_en),
        .busy       (busy),
        .echo_valid (echo_valid),
        .echo_ready (echo_ready),
        .echo_hit   (echo_hit),
        .echo_time  (echo_time),
        .echo_peak  (echo_peak)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        smp_valid = 1'b1;
        smp_data  = d;
        step();
        smp_valid = 1'b0;
        smp_data  = 8'd128;
    endtask

    task automatic set_cfg(input int t, input int b, input int l, input int g, input int thr);
        tx_len     = 16'(t);
        blank_len  = 16'(b);
        listen_len = 16'(l);
        gap_len    = 16'(g);
        threshold  = 8'(thr);
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic accept();
        echo_ready = 1'b1;
        step();
        echo_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({tx_en, rx_en, busy, echo_valid, echo_hit, echo_time, echo_peak} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {tx_en, rx_en, busy, echo_valid, echo_hit, echo_time, echo_peak});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_echo();
        int n_tx;
        int n;
        set_cfg(10, 5, 8, 0, 20);
        continuous = 1'b0;
        kick();
        tx_len = 16'd2;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_busy: got %b required 1", busy);
        end
        n_tx = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_en === 1'b1) n_tx++;
            step();
        end
        n_cmp++;
        if (n_tx != 10 || tx_en !== 1'b0 || rx_en !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_tx_cycles: got %0d tx_en=%b rx_en=%b required 10 0 1",
                     n_tx, tx_en, rx_en);
        end
        for (int i = 0; i < 5; i++) step();
        for (int i = 0; i < 8; i++) feed((i == 3) ? 8'd160 : 8'd128);
        n = 0;
        while (echo_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        n_cmp++;
        if (echo_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_valid_timeout: echo_valid=%b required 1", echo_valid);
        end
        feed(8'd0);
        n_cmp++;
        if (echo_hit !== 1'b1 || echo_time !== 16'd3 || echo_peak !== 8'd32) begin
            n_bad++;
            $display("FAIL basic_result: got hit=%b time=%0d peak=%0d required 1 3 32",
                     echo_hit, echo_time, echo_peak);
        end
        accept();
        n_cmp++;
        if (busy !== 1'b0 || echo_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_idle: got busy=%b valid=%b required 0 0", busy, echo_valid);
        end
    endtask

    task automatic test_no_hit();
        int n;
        set_cfg(1, 1, 4, 0, 1);
        continuous = 1'b0;
        kick();
        step();
        step();
        for (int i = 0; i < 4; i++) feed(8'd128);
        n = 0;
        while (echo_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        n_cmp++;
        if (echo_valid !== 1'b1 || echo_hit !== 1'b0 || echo_time !== 16'd0 || echo_peak !== 8'd0) begin
            n_bad++;
            $display("FAIL nohit_result: got valid=%b hit=%b time=%0d peak=%0d required 1 0 0 0",
                     echo_valid, echo_hit, echo_time, echo_peak);
        end
        accept();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL nohit_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_stall_continuous();
        int n;
        int n_tx;
        int bad_cycles;
        set_cfg(3, 2, 2, 7, 50);
        continuous = 1'b1;
        kick();
        for (int i = 0; i < 5; i++) step();
        feed(8'd100);
        feed(8'd200);
        n = 0;
        while (echo_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        n_cmp++;
        if (echo_valid !== 1'b1 || echo_hit !== 1'b1 || echo_time !== 16'd1 || echo_peak !== 8'd72) begin
            n_bad++;
            $display("FAIL stall_result: got valid=%b hit=%b time=%0d peak=%0d required 1 1 1 72",
                     echo_valid, echo_hit, echo_time, echo_peak);
        end
        tx_len = 16'd5;
        bad_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) feed(8'd0);
            else step();
            if (echo_valid !== 1'b1 || tx_en !== 1'b0 || echo_hit !== 1'b1 ||
                echo_time !== 16'd1 || echo_peak !== 8'd72) bad_cycles++;
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL stall_stable: got %0d unstable cycles required 0", bad_cycles);
        end
        accept();
        n = 0;
        while (tx_en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (n != 7 || tx_en !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_gap_len: got %0d cycles tx_en=%b required 7 1", n, tx_en);
        end
        continuous = 1'b0;
        n_tx = 0;
        for (int i = 0; i < 8; i++) begin
            if (tx_en === 1'b1) n_tx++;
            step();
        end
        n_cmp++;
        if (n_tx != 5) begin
            n_bad++;
            $display("FAIL stall_relatch_tx: got %0d tx cycles required 5", n_tx);
        end
        feed(8'd128);
        feed(8'd128);
        n_cmp++;
        if (echo_valid !== 1'b1 || echo_hit !== 1'b0 || echo_peak !== 8'd0) begin
            n_bad++;
            $display("FAIL stall_second_result: got valid=%b hit=%b peak=%0d required 1 0 0",
                     echo_valid, echo_hit, echo_peak);
        end
        accept();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_oneshot_idle: got busy=%b required 0", busy);
        end
        tx_len = 16'd0;
    endtask

    task automatic test_mag_extremes();
        set_cfg(1, 1, 4, 0, 128);
        continuous = 1'b0;
        kick();
        step();
        step();
        feed(8'd128);
        smp_data = 8'd0;
        step();
        smp_data = 8'd128;
        feed(8'd255);
        feed(8'd0);
        feed(8'd128);
        n_cmp++;
        if (echo_valid !== 1'b1 || echo_hit !== 1'b1 || echo_time !== 16'd2 || echo_peak !== 8'd128) begin
            n_bad++;
            $display("FAIL extremes_result: got valid=%b hit=%b time=%0d peak=%0d required 1 1 2 128",
                     echo_valid, echo_hit, echo_time, echo_peak);
        end
        accept();
    endtask

    task automatic test_zero_lengths();
        int n;
        logic tx_seen;
        set_cfg(0, 0, 0, 0, 10);
        continuous = 1'b0;
        tx_seen = 1'b0;
        kick();
        n = 1;
        if (tx_en === 1'b1) tx_seen = 1'b1;
        while (echo_valid !== 1'b1 && n < 6) begin
            step();
            n++;
            if (tx_en === 1'b1) tx_seen = 1'b1;
        end
        n_cmp++;
        if (echo_valid !== 1'b1 || n > 3 || tx_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_latency: got valid=%b cycles=%0d tx_seen=%b required 1 <=3 0",
                     echo_valid, n, tx_seen);
        end
        n_cmp++;
        if (echo_hit !== 1'b0 || echo_time !== 16'd0 || echo_peak !== 8'd0) begin
            n_bad++;
            $display("FAIL zero_result: got hit=%b time=%0d peak=%0d required 0 0 0",
                     echo_hit, echo_time, echo_peak);
        end
        accept();
    endtask

    task automatic test_threshold_zero();
        set_cfg(1, 0, 2, 0, 0);
        continuous = 1'b0;
        kick();
        step();
        feed(8'd128);
        feed(8'd128);
        n_cmp++;
        if (echo_valid !== 1'b1 || echo_hit !== 1'b1 || echo_time !== 16'd0 || echo_peak !== 8'd0) begin
            n_bad++;
            $display("FAIL thr0_result: got valid=%b hit=%b time=%0d peak=%0d required 1 1 0 0",
                     echo_valid, echo_hit, echo_time, echo_peak);
        end
        accept();
    endtask

    task automatic test_reset_mid_listen();
        set_cfg(2, 2, 10, 0, 10);
        continuous = 1'b0;
        kick();
        for (int i = 0; i < 4; i++) step();
        feed(8'd200);
        feed(8'd128);
        n_cmp++;
        if (rx_en !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_in_listen: got rx_en=%b busy=%b required 1 1", rx_en, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({tx_en, rx_en, busy, echo_valid, echo_hit, echo_time, echo_peak} !== 29'd0) begin
            n_bad++;
            $display("FAIL rstmid_async: got %b required all zero",
                     {tx_en, rx_en, busy, echo_valid, echo_hit, echo_time, echo_peak});
        end
        step();
        step();
        reset = 1'b0;
        step();
        set_cfg(1, 1, 3, 0, 10);
        kick();
        step();
        step();
        for (int i = 0; i < 3; i++) feed(8'd128);
        n_cmp++;
        if (echo_valid !== 1'b1 || echo_hit !== 1'b0 || echo_time !== 16'd0 || echo_peak !== 8'd0) begin
            n_bad++;
            $display("FAIL rstmid_fresh: got valid=%b hit=%b time=%0d peak=%0d required 1 0 0 0",
                     echo_valid, echo_hit, echo_time, echo_peak);
        end
        accept();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_idle: got busy=%b required 0", busy);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        smp_valid  = 1'b0;
        smp_data   = 8'd128;
        echo_ready = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        test_reset();
        test_basic_echo();
        test_no_hit();
        test_stall_continuous();
        test_mag_extremes();
        test_zero_lengths();
        test_threshold_zero();
        test_reset_mid_listen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
